job_address_gen: RTL and testbench
==================================

JOB_ADDRESS_GEN -- requirements
Module: job_address_gen

Interface
REQ-001 Parameter BUSWIDTH, 32, width of address and dimension buses.
REQ-002 Parameter ADDR_STEP, 4, byte increment per pixel (one pixel per bus word).
REQ-003 Parameter PEND_DEPTH, 4, maximum output pixels awaiting write acceptance.
REQ-004 ahb_hclk  in  1  bus clock; n_rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  job enable level from the AHB slave initializer (final_enable).
REQ-006 width, height  in  BUSWIDTH  image dimensions in pixels.
REQ-007 read_start_addr, write_start_addr  in  BUSWIDTH  source and destination base byte addresses.
REQ-008 rd_req  out  1  read request valid; rd_addr  out  BUSWIDTH  read byte address; rd_ack  in  1  master accepted read.
REQ-009 rd_row_last  out  1  current rd_addr is last pixel of a row.
REQ-010 out_pix_valid  in  1  one-cycle pulse from filter core: one output pixel ready.
REQ-011 wr_req  out  1  write request valid; wr_addr  out  BUSWIDTH  write byte address; wr_ack  in  1  master accepted write.
REQ-012 busy, done, err  out  1 each  job status.

Function
REQ-013 FSM states SHALL be IDLE, CHECK, RUN, DONE, ERROR.
REQ-014 IDLE: when start=1, latch width, height, both base addresses; next state CHECK.
REQ-015 CHECK (1 cycle): width<3, height<3, or any of bits [BUSWIDTH-1:16] of width/height set -> ERROR; else RUN.
REQ-016 RUN: rd_req=1 while reads issued < width*height; rd_addr = read base + ADDR_STEP*reads issued.
REQ-017 Read advances only on rd_req&rd_ack; rd_req/rd_addr held stable otherwise.
REQ-018 Column counter wraps at width-1 to 0 and increments row; rd_row_last=1 when column=width-1 and rd_req=1.
REQ-019 Pending counter: +1 on out_pix_valid, -1 on wr_req&wr_ack, unchanged when both occur same cycle.
REQ-020 wr_req=1 whenever pending>0; wr_addr = write base + ADDR_STEP*writes accepted.
REQ-021 Total writes = (width-2)*(height-2); out_pix_valid beyond total is ignored.
REQ-022 out_pix_valid when pending=PEND_DEPTH and no wr_ack same cycle -> ERROR (overflow).
REQ-023 RUN -> DONE when all reads issued, all writes accepted, pending=0.
REQ-024 DONE: done=1, no requests; start=0 -> IDLE.
REQ-025 ERROR: err=1, rd_req=wr_req=0; start=0 -> IDLE.
REQ-026 start=0 in CHECK or RUN aborts: next state IDLE, rd_req/wr_req low next cycle, counters cleared.
REQ-027 busy=1 in CHECK and RUN only.
REQ-028 All outputs registered; rd_req asserts 2 cycles after start sampled high in IDLE.
REQ-029 Address arithmetic modulo 2^BUSWIDTH; wrap is not an error.

Reset
REQ-030 n_rst low: state IDLE; rd_req, wr_req, busy, done, err, rd_row_last 0; rd_addr, wr_addr, all counters and latched inputs 0.
REQ-031 Reset mid-RUN discards job; after release, new job starts only on start sampled high in IDLE.

Structure
REQ-032 Package edge_pkg holds state enum, ADDR_STEP default, MIN_DIM=3 constant.
REQ-033 Column/row counting uses one sub-module instance type, flex_counter (clear, count_enable, rollover_val, count_out, rollover_flag).

Verification
REQ-034 width=4,height=4,read base 0x1000,write base 0x2000, rd_ack always 1 -> 16 reads 0x1000..0x103C, rd_row_last on 0x100C/0x101C/0x102C/0x103C; 4 out_pix_valid -> writes 0x2000..0x200C; done=1.
REQ-035 width=2,height=8 -> ERROR after CHECK, err=1, no rd_req; start=0 -> IDLE, err=0.
REQ-036 rd_ack low 3 cycles at read 5 -> rd_addr held 0x1014 for all 3 cycles, no skip or duplicate.
REQ-037 out_pix_valid and wr_ack same cycle with pending=1 -> pending stays 1; 5 pulses with wr_ack=0 -> err=1.
REQ-038 start dropped at read 7 -> rd_req=0 next cycle, state IDLE; restart gives rd_addr=read base.
REQ-039 n_rst asserted mid-RUN -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/edge_pkg.sv
// edge_pkg
//   Shared definitions for the job address generator: the job FSM state
//   encoding, the default byte step per pixel and the dimension limits that
//   decide whether a job can be run at all.
package edge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int ADDR_STEP_DEFAULT = 4;

  // Smallest dimension that still yields at least one output pixel of a
  // 3x3 filter window.
  localparam int MIN_DIM = 3;

  // Dimensions must fit in this many bits; column/row counters are this wide.
  localparam int DIM_BITS = 16;

endpackage

// File: rtl/job_address_gen_flex_counter.sv
// flex_counter
//   Wrapping up-counter: counts 0..rollover_val and returns to 0 on the next
//   enabled count. clear has priority over count_enable.
//   Ports:
//     ahb_hclk, n_rst   clock, asynchronous active-low reset
//     clear             synchronous return to 0
//     count_enable      advance by one
//     rollover_val      last value before wrapping
//     count_out         current count
//     rollover_flag     count_out equals rollover_val
module flex_counter
  import edge_pkg::*;
#(
  parameter int NUM_BITS = DIM_BITS
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  assign rollover_flag = (count_out == rollover_val);

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= rollover_flag ? '0 : count_out + ONE;
    end
  end

endmodule

// File: rtl/job_address_gen.sv
// job_address_gen
//   Generates the read address stream for one image job and the write
//   address stream for the filtered pixels coming back from the filter core.
//   A 3x3 filter produces (width-2)*(height-2) output pixels; reads cover the
//   whole image in raster order. All outputs are driven from flops.
//   Ports:
//     ahb_hclk, n_rst                 clock, asynchronous active-low reset
//     start                           job enable level (drop to abort/ack)
//     width, height                   image dimensions in pixels
//     read_start_addr/write_start_addr base byte addresses
//     rd_req/rd_addr/rd_row_last/rd_ack  read request channel
//     out_pix_valid                   one output pixel ready (pulse)
//     wr_req/wr_addr/wr_ack           write request channel
//     busy, done, err                 job status
module job_address_gen
  import edge_pkg::*;
#(
  parameter int BUSWIDTH   = 32,
  parameter int ADDR_STEP  = ADDR_STEP_DEFAULT,
  parameter int PEND_DEPTH = 4
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [BUSWIDTH-1:0] width,
  input  logic [BUSWIDTH-1:0] height,
  input  logic [BUSWIDTH-1:0] read_start_addr,
  input  logic [BUSWIDTH-1:0] write_start_addr,
  output logic                rd_req,
  output logic [BUSWIDTH-1:0] rd_addr,
  output logic                rd_row_last,
  input  logic                rd_ack,
  input  logic                out_pix_valid,
  output logic                wr_req,
  output logic [BUSWIDTH-1:0] wr_addr,
  input  logic                wr_ack,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int PW = $clog2(PEND_DEPTH + 1);
  localparam logic [PW-1:0]       PEND_MAX  = PW'(PEND_DEPTH);
  localparam logic [BUSWIDTH-1:0] STEP      = BUSWIDTH'(ADDR_STEP);
  localparam logic [BUSWIDTH-1:0] MIN_DIM_W = BUSWIDTH'(MIN_DIM);
  localparam logic [BUSWIDTH-1:0] TWO       = BUSWIDTH'(2);
  localparam logic [BUSWIDTH-1:0] ONE_W     = BUSWIDTH'(1);
  localparam logic [DIM_BITS-1:0] ONE_D     = DIM_BITS'(1);

  state_t state, state_next;

  logic [BUSWIDTH-1:0] w_lat, h_lat, total_wr, wr_count, pix_count;
  logic [PW-1:0]       pending, pending_next;
  logic                reads_done, reads_done_next;
  logic [DIM_BITS-1:0] col_count, row_count, col_max, row_max;
  logic                col_wrap, row_wrap, cnt_clear;
  logic                rd_fire, wr_fire, pix_acc, overflow, dims_bad, all_done;
  logic                job_start, job_abort;
  logic                rd_req_next, wr_req_next, col_last_next;
  logic                unused_row;

  assign total_wr = (w_lat - TWO) * (h_lat - TWO);
  assign col_max  = w_lat[DIM_BITS-1:0] - ONE_D;
  assign row_max  = h_lat[DIM_BITS-1:0] - ONE_D;

  // Only the row wrap flag matters (it marks the final image row); the row
  // index itself is not needed.
  assign unused_row = &{1'b0, row_count};

  flex_counter #(.NUM_BITS(DIM_BITS)) u_col_counter (
    .ahb_hclk      (ahb_hclk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (rd_fire),
    .rollover_val  (col_max),
    .count_out     (col_count),
    .rollover_flag (col_wrap)
  );

  flex_counter #(.NUM_BITS(DIM_BITS)) u_row_counter (
    .ahb_hclk      (ahb_hclk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (rd_fire & col_wrap),
    .rollover_val  (row_max),
    .count_out     (row_count),
    .rollover_flag (row_wrap)
  );

  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic plus the next values of every registered output, so
  // the outputs change on the same edge as the state they describe.
  always_comb begin
    rd_fire  = rd_req & rd_ack;
    wr_fire  = wr_req & wr_ack;
    dims_bad = (w_lat < MIN_DIM_W) || (h_lat < MIN_DIM_W) ||
               ((w_lat >> DIM_BITS) != '0) || ((h_lat >> DIM_BITS) != '0);
    // Pixels beyond the job total are stray pulses and are dropped.
    pix_acc  = (state == RUN) && out_pix_valid && (pix_count < total_wr);
    overflow = pix_acc && (pending == PEND_MAX) && !wr_fire;
    all_done = reads_done && (wr_count == total_wr) && (pending == '0);

    state_next = state;
    case (state)
      IDLE:  if (start) state_next = CHECK;
      CHECK: begin
        if (!start)        state_next = IDLE;
        else if (dims_bad) state_next = ERROR;
        else               state_next = RUN;
      end
      RUN: begin
        if (!start)        state_next = IDLE;
        else if (overflow) state_next = ERROR;
        else if (all_done) state_next = DONE;
      end
      DONE:    if (!start) state_next = IDLE;
      ERROR:   if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    job_start = (state == IDLE) && start;
    job_abort = ((state == CHECK) || (state == RUN)) && !start;
    cnt_clear = (state_next != RUN);

    reads_done_next = reads_done;
    pending_next    = pending;
    if (job_start || job_abort) begin
      reads_done_next = 1'b0;
      pending_next    = '0;
    end else if ((state == RUN) && !overflow) begin
      if (rd_fire && col_wrap && row_wrap) reads_done_next = 1'b1;
      pending_next = pending + PW'(pix_acc) - PW'(wr_fire);
    end

    // Will the column counter sit on the last column after this edge?
    col_last_next = 1'b0;
    if (!cnt_clear) begin
      col_last_next = rd_fire ? (!col_wrap && ((col_count + ONE_D) == col_max))
                              : col_wrap;
    end

    rd_req_next = (state_next == RUN) && !reads_done_next;
    wr_req_next = (state_next == RUN) && (pending_next != '0);
  end

  // Registered status and request outputs.
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      rd_req      <= 1'b0;
      wr_req      <= 1'b0;
      rd_row_last <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      reads_done  <= 1'b0;
      pending     <= '0;
    end else begin
      rd_req      <= rd_req_next;
      wr_req      <= wr_req_next;
      rd_row_last <= rd_req_next && col_last_next;
      busy        <= (state_next == CHECK) || (state_next == RUN);
      done        <= (state_next == DONE);
      err         <= (state_next == ERROR);
      reads_done  <= reads_done_next;
      pending     <= pending_next;
    end
  end

  // Job parameters and address/progress counters. Addresses are loaded with
  // the bases when the job is latched, so they are already correct on the
  // first RUN cycle; arithmetic simply wraps at the bus width.
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      w_lat     <= '0;
      h_lat     <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_count  <= '0;
      pix_count <= '0;
    end else if (job_start) begin
      w_lat     <= width;
      h_lat     <= height;
      rd_addr   <= read_start_addr;
      wr_addr   <= write_start_addr;
      wr_count  <= '0;
      pix_count <= '0;
    end else if (job_abort) begin
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_count  <= '0;
      pix_count <= '0;
    end else if ((state == RUN) && !overflow) begin
      if (rd_fire) rd_addr <= rd_addr + STEP;
      if (wr_fire) begin
        wr_addr  <= wr_addr + STEP;
        wr_count <= wr_count + ONE_W;
      end
      if (pix_acc) pix_count <= pix_count + ONE_W;
    end
  end

endmodule

// File: tb/tb_job_address_gen.sv
// tb_job_address_gen
//   Self-checking bench for job_address_gen. A transaction-level model keeps
//   the expected read/write address sequences (base + 4*index), row-end
//   positions and the count of output pixels awaiting write acceptance, and
//   every cycle is compared against it under randomized handshakes.
module tb_job_address_gen;

  localparam int BW   = 32;
  localparam int STEP = 4;
  localparam int PD   = 4;

  logic          ahb_hclk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [BW-1:0] width, height, read_start_addr, write_start_addr;
  logic          rd_req, rd_row_last, rd_ack;
  logic [BW-1:0] rd_addr, wr_addr;
  logic          out_pix_valid, wr_req, wr_ack;
  logic          busy, done, err;

  int num_checks = 0;
  int num_fail   = 0;

  job_address_gen #(.BUSWIDTH(BW), .ADDR_STEP(STEP), .PEND_DEPTH(PD)) dut (
    .ahb_hclk         (ahb_hclk),
    .n_rst            (n_rst),
    .start            (start),
    .width            (width),
    .height           (height),
    .read_start_addr  (read_start_addr),
    .write_start_addr (write_start_addr),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_row_last      (rd_row_last),
    .rd_ack           (rd_ack),
    .out_pix_valid    (out_pix_valid),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_ack           (wr_ack),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 ahb_hclk = ~ahb_hclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_rdreq"}, rd_req, 0);
    checkOutput({tag, "_wrreq"}, wr_req, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Drive a job into the DUT and step through the CHECK cycle; the caller's
  // next negedge is the first cycle after CHECK.
  task automatic startJob(input int w, input int h, input logic [31:0] rb, input logic [31:0] wb);
    @(negedge ahb_hclk);
    start = 1; width = w; height = h;
    read_start_addr = rb; write_start_addr = wb;
    rd_ack = 0; wr_ack = 0; out_pix_valid = 0;
    @(negedge ahb_hclk);
    checkOutput("check_busy", busy, 1);
    checkOutput("check_rdreq", rd_req, 0);
  endtask

  // Full job against the model. ack_pct=100 means acks always high;
  // stall_at holds rd_ack low for 3 cycles when that many reads are issued;
  // abort_at drops start when that many reads are issued.
  task automatic applyStimulus(input int w, input int h, input logic [31:0] rb,
                               input logic [31:0] wb, input int ack_pct,
                               input int stall_at, input int abort_at, input bit extra_pulses);
    int total_rd, total_wr, idx, widx, pix, pend, stall_left;
    bit finished, wfire;
    total_rd = w * h; total_wr = (w - 2) * (h - 2);
    idx = 0; widx = 0; pix = 0; pend = 0; stall_left = 3; finished = 0;
    startJob(w, h, rb, wb);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge ahb_hclk);
      if (idx == total_rd && widx == total_wr && pend == 0) begin
        rd_ack = 0; wr_ack = 0; out_pix_valid = 0;
        checkOutput("final_busy", busy, 1);
        checkOutput("final_done", done, 0);
        checkOutput("final_rdreq", rd_req, 0);
        checkOutput("final_wrreq", wr_req, 0);
        @(negedge ahb_hclk);
        checkOutput("done", done, 1);
        checkOutput("done_err", err, 0);
        checkQuiet("done");
        start = 0;
        @(negedge ahb_hclk);
        checkOutput("idle_done", done, 0);
        checkQuiet("idle");
        finished = 1;
      end else begin
        checkOutput("run_busy", busy, 1);
        checkOutput("run_done", done, 0);
        checkOutput("run_err", err, 0);
        checkOutput("rd_req", rd_req, idx < total_rd);
        if (idx < total_rd) begin
          checkOutput("rd_addr", rd_addr, rb + 32'(STEP * idx));
          checkOutput("rd_row_last", rd_row_last, (idx % w) == (w - 1));
        end else begin
          checkOutput("rd_row_last_idle", rd_row_last, 0);
        end
        checkOutput("wr_req", wr_req, pend > 0);
        if (pend > 0) checkOutput("wr_addr", wr_addr, wb + 32'(STEP * widx));
        if (abort_at >= 0 && idx == abort_at) begin
          start = 0; rd_ack = 0; wr_ack = 0; out_pix_valid = 0;
          @(negedge ahb_hclk);
          checkQuiet("abort");
          checkOutput("abort_rowlast", rd_row_last, 0);
          finished = 1;
        end else begin
          if (idx == stall_at && stall_left > 0) begin
            rd_ack = 0; stall_left--;
          end else begin
            rd_ack = (ack_pct >= 100) ? 1'b1 : ($urandom_range(99) < ack_pct);
          end
          wr_ack = (ack_pct >= 100) ? 1'b1 : ($urandom_range(99) < ack_pct);
          wfire = (pend > 0) && wr_ack;
          if (pix < total_wr)
            out_pix_valid = ($urandom_range(1) == 1) && ((pend < PD) || wfire);
          else
            out_pix_valid = extra_pulses && ($urandom_range(3) == 0);
          if (idx < total_rd && rd_ack) idx++;
          if (wfire) begin widx++; pend--; end
          if (out_pix_valid && pix < total_wr) begin pix++; pend++; end
        end
      end
    end
    if (!finished) begin
      checkOutput("job_timeout", 0, 1);
      start = 0;
    end
    rd_ack = 0; wr_ack = 0; out_pix_valid = 0;
  endtask

  task automatic errorJob(input int w, input int h);
    startJob(w, h, 32'h1000, 32'h2000);
    rd_ack = 1;
    @(negedge ahb_hclk);
    checkOutput("err_set", err, 1);
    checkQuiet("err");
    @(negedge ahb_hclk);
    checkOutput("err_hold", err, 1);
    checkOutput("err_hold_rdreq", rd_req, 0);
    start = 0; rd_ack = 0;
    @(negedge ahb_hclk);
    checkOutput("err_clear", err, 0);
    checkQuiet("err_idle");
  endtask

  // A pixel arriving with a write acceptance leaves exactly one pending.
  task automatic pendingTest();
    startJob(5, 5, 32'h1000, 32'h2000);
    @(negedge ahb_hclk);
    out_pix_valid = 1;
    @(negedge ahb_hclk);
    checkOutput("pend_one", wr_req, 1);
    wr_ack = 1;
    @(negedge ahb_hclk);
    checkOutput("pend_same_wrreq", wr_req, 1);
    checkOutput("pend_same_addr", wr_addr, 32'h2004);
    out_pix_valid = 0;
    @(negedge ahb_hclk);
    checkOutput("pend_drain", wr_req, 0);
    checkOutput("pend_drain_addr", wr_addr, 32'h2008);
    wr_ack = 0; start = 0;
    @(negedge ahb_hclk);
    checkQuiet("pend_abort");
  endtask

  task automatic overflowTest();
    startJob(5, 5, 32'h1000, 32'h2000);
    for (int i = 0; i < 5; i++) begin
      @(negedge ahb_hclk);
      if (i == 4) checkOutput("ovf_not_yet", err, 0);
      out_pix_valid = 1;
    end
    @(negedge ahb_hclk);
    out_pix_valid = 0;
    checkOutput("ovf_err", err, 1);
    checkQuiet("ovf");
    start = 0;
    @(negedge ahb_hclk);
    checkOutput("ovf_clear", err, 0);
  endtask

  task automatic resetMidRun();
    startJob(6, 6, 32'h3000, 32'h4000);
    rd_ack = 1;
    @(negedge ahb_hclk);
    out_pix_valid = 1;
    @(negedge ahb_hclk);
    out_pix_valid = 0;
    @(negedge ahb_hclk);
    checkOutput("pre_rst_wrreq", wr_req, 1);
    #2 n_rst = 0;
    #1;
    checkOutput("rst_rdreq", rd_req, 0);
    checkOutput("rst_wrreq", wr_req, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rdaddr", rd_addr, 0);
    checkOutput("rst_wraddr", wr_addr, 0);
    checkOutput("rst_rowlast", rd_row_last, 0);
    start = 0; rd_ack = 0;
    @(negedge ahb_hclk);
    n_rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ahb_hclk);
      checkQuiet("post_rst");
    end
  endtask

  initial begin
    n_rst = 1; start = 0; rd_ack = 0; wr_ack = 0; out_pix_valid = 0;
    width = 0; height = 0; read_start_addr = 0; write_start_addr = 0;
    #1 n_rst = 0;
    #2;
    checkOutput("reset_rdreq", rd_req, 0);
    checkOutput("reset_wrreq", wr_req, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_rowlast", rd_row_last, 0);
    checkOutput("reset_rdaddr", rd_addr, 0);
    checkOutput("reset_wraddr", wr_addr, 0);
    @(negedge ahb_hclk);
    @(negedge ahb_hclk);
    n_rst = 1;

    $display("[TB] basic 4x4 job");
    applyStimulus(4, 4, 32'h1000, 32'h2000, 100, -1, -1, 0);
    $display("[TB] narrow image rejected");
    errorJob(2, 8);
    errorJob(32'h0001_0004, 4);
    errorJob(5, 32'h8000_0003);
    $display("[TB] read stall at read 5");
    applyStimulus(4, 4, 32'h1000, 32'h2000, 100, 5, -1, 0);
    pendingTest();
    overflowTest();
    $display("[TB] abort at read 7 then restart");
    applyStimulus(4, 4, 32'h1000, 32'h2000, 100, -1, 7, 0);
    applyStimulus(4, 4, 32'h1000, 32'h2000, 100, -1, -1, 0);
    $display("[TB] minimum size and address wrap");
    applyStimulus(3, 3, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 70, -1, -1, 1);
    $display("[TB] randomized jobs");
    for (int j = 0; j < 6; j++) begin
      applyStimulus($urandom_range(3, 7), $urandom_range(3, 6),
                    $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    $urandom_range(40, 90), -1, -1, 1);
    end
    resetMidRun();
    applyStimulus(3, 4, 32'h5000, 32'h6000, 100, -1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
